// File: rtl/nws_pkg.sv
// Shared types and constants for the neuron_core Wishbone sequencer:
// FSM state encoding, register offsets and default timeout.
package nws_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVT  = 2'd1,
        ST_TICK = 2'd2,
        ST_READ = 2'd3
    } nws_state_e;

    localparam logic [31:0] REG_AXON_OFS = 32'h0000_0000;
    localparam logic [31:0] REG_TICK_OFS = 32'h0000_0004;
    localparam logic [31:0] REG_OUT_OFS  = 32'h0000_0008;

    localparam logic [31:0] TICK_WORD = 32'h0000_0001;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [31:0] ofs);
        return base + ofs;
    endfunction

endpackage

// File: rtl/nws_event_fifo.sv
// Synchronous first-word-fall-through FIFO for spike events.
// head_o shows the oldest entry whenever empty_o is low; a full FIFO refuses pushes.
module nws_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty_o = (r_wr_ptr == r_rd_ptr);
    assign count_o = r_wr_ptr - r_rd_ptr;
    assign head_o  = r_mem[r_rd_ptr[AW-1:0]];

    assign w_push = push_i && !full_o;
    assign w_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/neuron_wb_sequencer.sv
// Buffers spike events and, per time-step tick, drives neuron_core over Wishbone:
// AXON writes for queued events, a TICK write, then an OUT read. Optional ack timeout: NWS_TIMEOUT_EN.
module neuron_wb_sequencer
    import nws_pkg::*;
#(
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        evt_valid_i,
    input  logic [7:0]  evt_axon_i,
    output logic        evt_ready_o,
    input  logic        tick_i,
    output logic        busy_o,
    output logic        out_valid_o,
    output logic [31:0] out_data_o,
    output logic        err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] ADR_AXON = reg_addr(BASE_ADDR, REG_AXON_OFS);
    localparam logic [31:0] ADR_TICK = reg_addr(BASE_ADDR, REG_TICK_OFS);
    localparam logic [31:0] ADR_OUT  = reg_addr(BASE_ADDR, REG_OUT_OFS);

    // Marker scope that elaborates only for unsupported parameter values.
    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_illegal
        end
    endgenerate

    nws_state_e     r_state;
    logic [CW-1:0]  r_drain_cnt;
    logic           r_pending;
    logic           r_cyc;
    logic           r_we;
    logic [31:0]    r_adr;
    logic [31:0]    r_dat;
    logic           r_out_valid;
    logic [31:0]    r_out_data;

    logic           w_full;
    logic           w_empty;
    logic [7:0]     w_head;
    logic [CW-1:0]  w_count;
    logic           w_push;
    logic           w_pop;
    logic           w_start;
    logic           w_timeout;

    assign w_push  = evt_valid_i && !w_full;
    assign w_pop   = (r_state == ST_EVT) && r_cyc && wbm_ack_i && !w_timeout;
    assign w_start = tick_i || r_pending;

    nws_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (w_push),
        .push_data_i (evt_axon_i),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count)
    );

`ifdef NWS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_err;

    // Counts cycles the current strobe has gone unanswered.
    assign w_timeout = r_cyc && !wbm_ack_i && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_cyc && !wbm_ack_i && !w_timeout) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
            r_pending   <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (tick_i && r_state != ST_IDLE) begin
                r_pending <= 1'b1;
            end

            if (w_timeout) begin
                r_cyc       <= 1'b0;
                r_drain_cnt <= '0;
                r_state     <= ST_IDLE;
            end else begin
                // Within a busy state, r_cyc low means the next transaction is due.
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_pending   <= 1'b0;
                            r_drain_cnt <= w_count;
                            r_cyc       <= 1'b1;
                            r_we        <= 1'b1;
                            if (w_count != '0) begin
                                r_state <= ST_EVT;
                                r_adr   <= ADR_AXON;
                                r_dat   <= {24'h0, w_head};
                            end else begin
                                r_state <= ST_TICK;
                                r_adr   <= ADR_TICK;
                                r_dat   <= TICK_WORD;
                            end
                        end
                    end
                    ST_EVT: begin
                        if (!r_cyc) begin
                            if (!w_empty) begin
                                r_cyc <= 1'b1;
                                r_we  <= 1'b1;
                                r_adr <= ADR_AXON;
                                r_dat <= {24'h0, w_head};
                            end
                        end else if (wbm_ack_i) begin
                            r_cyc       <= 1'b0;
                            r_drain_cnt <= r_drain_cnt - 1'b1;
                            if (r_drain_cnt == CW'(1)) begin
                                r_state <= ST_TICK;
                            end
                        end
                    end
                    ST_TICK: begin
                        if (!r_cyc) begin
                            r_cyc <= 1'b1;
                            r_we  <= 1'b1;
                            r_adr <= ADR_TICK;
                            r_dat <= TICK_WORD;
                        end else if (wbm_ack_i) begin
                            r_cyc   <= 1'b0;
                            r_state <= ST_READ;
                        end
                    end
                    ST_READ: begin
                        if (!r_cyc) begin
                            r_cyc <= 1'b1;
                            r_we  <= 1'b0;
                            r_adr <= ADR_OUT;
                            r_dat <= '0;
                        end else if (wbm_ack_i) begin
                            r_cyc       <= 1'b0;
                            r_out_data  <= wbm_dat_i;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_cyc   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign evt_ready_o = !w_full;
    assign busy_o      = (r_state != ST_IDLE);
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_sel_o   = 4'hF;

endmodule
